// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: each input word is steered by in_sel into one of
// four output channel registers, and each channel has its own valid/ready handshake.
module demux_1to4_stream #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [CNT_W-1:0]   xfer_cnt,
   output logic               idle
);

   logic [3:0]       vld_p0;
   logic [WIDTH-1:0] data_p0 [4];
   logic [CNT_W-1:0] cnt_p0;
   logic             accept;
   logic [3:0]       load;
   logic [3:0]       drain;

   // A full channel can still accept when its consumer drains it in the same cycle.
   assign in_ready = ~vld_p0[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;
   assign drain    = vld_p0 & out_ready;

   always_comb begin
      load         = '0;
      load[in_sel] = accept;
   end

   // ---- stage p0: channel registers and accept counter ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= '0;
         cnt_p0 <= '0;
         for (int k = 0; k < 4; k++) begin
            data_p0[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
               vld_p0[k]  <= 1'b1;
               data_p0[k] <= in_data;
            end else if (drain[k]) begin
               vld_p0[k]  <= 1'b0;
            end
         end
         if (accept) begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
         end
      end
   end

   always_comb begin
      out_data = '0;
      for (int k = 0; k < 4; k++) begin
         out_data[k*WIDTH +: WIDTH] = data_p0[k];
      end
   end

   assign out_valid = vld_p0;
   assign xfer_cnt  = cnt_p0;
   assign idle      = ~|vld_p0;

endmodule
